sdram_arbiter: RTL and testbench

Parametrised N-channel SDRAM access arbiter and data demux for the NeoGeo core. It is the generalised successor of the fixed four-requester SDRAM mux.
- Each channel raises a trigger. The arbiter captures the trigger as a pending request and grants one channel at a time, using fixed or rotating priority.
- For the granted channel it drives address, data and byte mask to the SDRAM controller, issues a one-cycle RD/WR pulse, and latches returned data into that channel's output register.
- HPS download pass-through overrides all channels.

---
 rtl/sdram_arbiter.sv | 177 +++++++++++++++++
 tb/tb_sdram_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// N-channel SDRAM access arbiter with per-channel read-data registers and HPS download pass-through.
// Optional ROUND_ROBIN_EN: rotating grant priority; default is fixed lowest-index-first.
module sdram_arbiter #(
  parameter int NCH = 4,
  parameter int AW  = 25,
  parameter int DW  = 16,
  parameter int RW  = 64,
  parameter logic [NCH-1:0] WIDE_MASK = NCH'(4'b0100)
) (
  input  logic              clk_sys,
  input  logic              RESET,
  input  logic [NCH-1:0]    REQ_TRIG,
  input  logic [NCH-1:0]    REQ_EN,
  input  logic [NCH-1:0]    REQ_WR,
  input  logic [NCH-1:0]    REQ_BYTE,
  input  logic [NCH*AW-1:0] REQ_ADDR,
  input  logic [NCH*DW-1:0] REQ_DIN,
  output logic [NCH*RW-1:0] CH_DATA,
  output logic [NCH-1:0]    CH_VALID,
  output logic [NCH-1:0]    CH_BUSY,
  output logic [NCH-1:0]    OVERRUN,
  input  logic              DL_ACTIVE,
  input  logic [AW-1:0]     DL_ADDR,
  input  logic [DW-1:0]     DL_DIN,
  output logic [AW-1:0]     sdram_addr,
  output logic [DW-1:0]     sdram_din,
  output logic [1:0]        wtbt,
  output logic              SDRAM_RD_PULSE,
  output logic              SDRAM_WR_PULSE,
  input  logic              sdram_ready,
  input  logic              ready_fourth,
  input  logic [RW-1:0]     sdram_dout
);

  // state | meaning
  // IDLE  | waiting for a pending request while the controller is ready
  // ISSUE | one-cycle RD/WR pulse for the granted channel
  // WAIT  | waiting for the completion edge (ready_fourth for wide channels)
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;

  state_t            state_q, state_d;
  logic [NCH-1:0]    trig_s0_q, trig_s0_d, trig_s1_q, trig_s1_d;
  logic [1:0]        rdy_sr_q, rdy_sr_d, r4_sr_q, r4_sr_d;
  logic [NCH-1:0]    pend_q, pend_d;
  logic [NCH-1:0]    overrun_q, overrun_d;
  logic [NCH-1:0]    valid_q, valid_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [NCH*RW-1:0] ch_data_q, ch_data_d;
`ifdef ROUND_ROBIN_EN
  logic [GW-1:0]     last_q, last_d;
`endif

  logic [NCH-1:0]    det;
  logic [GW-1:0]     win;
  logic              done;

  // Descending scan so the highest-priority candidate is assigned last.
  always_comb begin
    win = '0;
`ifdef ROUND_ROBIN_EN
    for (int k = NCH - 1; k >= 0; k--) begin
      if (pend_q[(int'(last_q) + 1 + k) % NCH]) win = GW'((int'(last_q) + 1 + k) % NCH);
    end
`else
    for (int k = NCH - 1; k >= 0; k--) begin
      if (pend_q[k]) win = GW'(k);
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    trig_s0_d = REQ_TRIG;
    trig_s1_d = trig_s0_q;
    rdy_sr_d  = {rdy_sr_q[0], sdram_ready};
    r4_sr_d   = {r4_sr_q[0], ready_fourth};
    det       = trig_s0_q & ~trig_s1_q;
    pend_d    = pend_q | det;
    overrun_d = overrun_q | (det & pend_q);
    valid_d   = '0;
    grant_d   = grant_q;
    ch_data_d = ch_data_q;
`ifdef ROUND_ROBIN_EN
    last_d    = last_q;
`endif
    done = WIDE_MASK[grant_q] ? (r4_sr_q == 2'b01) : (rdy_sr_q == 2'b01);

    case (state_q)
      S_IDLE: begin
        if (!DL_ACTIVE && sdram_ready && (|pend_q)) begin
          // A fresh detect on the winner keeps it pending for a follow-up access.
          pend_d[win] = det[win];
          grant_d     = win;
          if (REQ_EN[win]) begin
            state_d = S_ISSUE;
`ifdef ROUND_ROBIN_EN
            last_d  = win;
`endif
          end
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (done) begin
          if (!REQ_WR[grant_q]) begin
            ch_data_d[int'(grant_q)*RW +: RW] =
              WIDE_MASK[grant_q] ? sdram_dout : RW'(sdram_dout[RW-1 -: 16]);
          end
          valid_d[grant_q] = 1'b1;
          state_d          = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sdram_addr     = '0;
    sdram_din      = '0;
    wtbt           = 2'b11;
    SDRAM_RD_PULSE = 1'b0;
    SDRAM_WR_PULSE = 1'b0;
    CH_BUSY        = pend_q;
    if (state_q != S_IDLE) CH_BUSY[grant_q] = 1'b1;
    if (state_q == S_ISSUE) begin
      SDRAM_WR_PULSE = REQ_WR[grant_q];
      SDRAM_RD_PULSE = !REQ_WR[grant_q];
    end
    if (DL_ACTIVE) begin
      sdram_addr = DL_ADDR;
      sdram_din  = DL_DIN;
    end else if (state_q != S_IDLE) begin
      sdram_addr = REQ_ADDR[int'(grant_q)*AW +: AW];
      sdram_din  = REQ_DIN[int'(grant_q)*DW +: DW];
      if (REQ_WR[grant_q] && REQ_BYTE[grant_q]) wtbt = 2'b00;
    end
  end

  assign CH_DATA  = ch_data_q;
  assign CH_VALID = valid_q;
  assign OVERRUN  = overrun_q;

  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      trig_s0_q <= '0;
      trig_s1_q <= '0;
      rdy_sr_q  <= '0;
      r4_sr_q   <= '0;
      pend_q    <= '0;
      overrun_q <= '0;
      valid_q   <= '0;
      grant_q   <= '0;
      ch_data_q <= '0;
`ifdef ROUND_ROBIN_EN
      last_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      trig_s0_q <= trig_s0_d;
      trig_s1_q <= trig_s1_d;
      rdy_sr_q  <= rdy_sr_d;
      r4_sr_q   <= r4_sr_d;
      pend_q    <= pend_d;
      overrun_q <= overrun_d;
      valid_q   <= valid_d;
      grant_q   <= grant_d;
      ch_data_q <= ch_data_d;
`ifdef ROUND_ROBIN_EN
      last_q    <= last_d;
`endif
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: expected accesses queued at trigger time, checked at pulse and CH_VALID.
module tb_sdram_arbiter;
  localparam int NCH = 4;
  localparam int AW  = 25;
  localparam int DW  = 16;
  localparam int RW  = 64;

  logic              clk_sys = 1'b0;
  logic              RESET;
  logic [NCH-1:0]    REQ_TRIG, REQ_EN, REQ_WR, REQ_BYTE;
  logic [NCH*AW-1:0] REQ_ADDR;
  logic [NCH*DW-1:0] REQ_DIN;
  logic [NCH*RW-1:0] CH_DATA;
  logic [NCH-1:0]    CH_VALID, CH_BUSY, OVERRUN;
  logic              DL_ACTIVE;
  logic [AW-1:0]     DL_ADDR;
  logic [DW-1:0]     DL_DIN;
  logic [AW-1:0]     sdram_addr;
  logic [DW-1:0]     sdram_din;
  logic [1:0]        wtbt;
  logic              SDRAM_RD_PULSE, SDRAM_WR_PULSE;
  logic              sdram_ready, ready_fourth;
  logic [RW-1:0]     sdram_dout;

  sdram_arbiter dut (
    .clk_sys(clk_sys), .RESET(RESET),
    .REQ_TRIG(REQ_TRIG), .REQ_EN(REQ_EN), .REQ_WR(REQ_WR), .REQ_BYTE(REQ_BYTE),
    .REQ_ADDR(REQ_ADDR), .REQ_DIN(REQ_DIN),
    .CH_DATA(CH_DATA), .CH_VALID(CH_VALID), .CH_BUSY(CH_BUSY), .OVERRUN(OVERRUN),
    .DL_ACTIVE(DL_ACTIVE), .DL_ADDR(DL_ADDR), .DL_DIN(DL_DIN),
    .sdram_addr(sdram_addr), .sdram_din(sdram_din), .wtbt(wtbt),
    .SDRAM_RD_PULSE(SDRAM_RD_PULSE), .SDRAM_WR_PULSE(SDRAM_WR_PULSE),
    .sdram_ready(sdram_ready), .ready_fourth(ready_fourth), .sdram_dout(sdram_dout)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    int            ch;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [1:0]    wtbt;
    logic [RW-1:0] dout;
    logic [RW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  int            vectors = 0;
  int            miscompares = 0;
  int            cyc = 0;
  int            pulse_cnt = 0;
  int            pulse_cyc = 0;
  int            trig_cyc = 0;
  int            ctrl_cnt = 0;
  logic          ctrl_wide = 1'b0;
  logic [RW-1:0] ctrl_val = '0;
  logic [3:0]    wide_m = 4'b0100;

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #2;
  endtask

  task automatic push_exp(input int ch, input logic [RW-1:0] dout);
    exp_t e;
    e.ch   = ch;
    e.wr   = REQ_WR[ch];
    e.addr = REQ_ADDR[ch*AW +: AW];
    e.din  = REQ_DIN[ch*DW +: DW];
    e.wtbt = (REQ_WR[ch] && REQ_BYTE[ch]) ? 2'b00 : 2'b11;
    e.dout = dout;
    e.data = wide_m[ch] ? dout : {48'h0, dout[63:48]};
    exp_q.push_back(e);
  endtask

  task automatic pulse_trig(input logic [3:0] m);
    REQ_TRIG = m;
    trig_cyc = cyc;
    tick();
    REQ_TRIG = '0;
    tick();
  endtask

  task automatic wait_pulse(input int n0);
    int b = 0;
    while (pulse_cnt == n0 && b < 50) begin
      tick();
      b++;
    end
    check_val("pulse_timeout", 64'(pulse_cnt != n0), 1);
  endtask

  task automatic wait_idle();
    int b = 0;
    while ((exp_q.size() != 0 || CH_BUSY != 0) && b < 200) begin
      tick();
      b++;
    end
    check_val("idle_timeout", 64'(exp_q.size() == 0 && CH_BUSY == 0), 1);
  endtask

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < NCH; i++) check_val({tag, "_ch_data"}, CH_DATA[i*RW +: RW], 0);
    check_val({tag, "_valid"}, CH_VALID, 0);
    check_val({tag, "_busy"}, CH_BUSY, 0);
    check_val({tag, "_overrun"}, OVERRUN, 0);
    check_val({tag, "_addr"}, sdram_addr, 0);
    check_val({tag, "_din"}, sdram_din, 0);
    check_val({tag, "_wtbt"}, wtbt, 2'b11);
    check_val({tag, "_pulses"}, {SDRAM_RD_PULSE, SDRAM_WR_PULSE}, 0);
  endtask

  // SDRAM controller model and output monitor.
  initial begin
    exp_t e;
    sdram_ready  = 1'b1;
    ready_fourth = 1'b0;
    sdram_dout   = '0;
    forever begin
      @(negedge clk_sys);
      if (RESET) begin
        sdram_ready  = 1'b1;
        ready_fourth = 1'b0;
        ctrl_cnt     = 0;
      end else begin
        if (ctrl_cnt > 0) begin
          ctrl_cnt++;
          if (ctrl_cnt == 4) begin
            sdram_ready = 1'b1;
            if (!ctrl_wide) begin
              sdram_dout = ctrl_val;
              ctrl_cnt   = 0;
            end
          end else if (ctrl_cnt == 9) begin
            sdram_dout   = ctrl_val;
            ready_fourth = 1'b1;
            ctrl_cnt     = 0;
          end
        end
        if (SDRAM_RD_PULSE || SDRAM_WR_PULSE) begin
          pulse_cnt++;
          pulse_cyc = cyc;
          check_val("pulse_expected", 64'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q[0];
            check_val("pulse_wr", SDRAM_WR_PULSE, e.wr);
            check_val("pulse_rd", SDRAM_RD_PULSE, !e.wr);
            check_val("issue_addr", sdram_addr, e.addr);
            check_val("issue_din", sdram_din, e.din);
            check_val("issue_wtbt", wtbt, e.wtbt);
            ctrl_wide = wide_m[e.ch];
            ctrl_val  = e.dout;
          end else begin
            ctrl_wide = 1'b0;
            ctrl_val  = '0;
          end
          sdram_ready  = 1'b0;
          ready_fourth = 1'b0;
          sdram_dout   = ~ctrl_val;
          ctrl_cnt     = 1;
        end
        if (CH_VALID != 0) begin
          check_val("valid_expected", 64'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_val("valid_ch", CH_VALID, 64'(1) << e.ch);
            if (!e.wr) check_val("ch_data", CH_DATA[e.ch*RW +: RW], e.data);
          end
        end
      end
    end
  end

  initial begin
    int n0;
    RESET = 1'b1; REQ_TRIG = '0; REQ_EN = '1; REQ_WR = '0; REQ_BYTE = '0;
    REQ_ADDR = '0; REQ_DIN = '0; DL_ACTIVE = 1'b0; DL_ADDR = '0; DL_DIN = '0;
    repeat (3) tick();
    RESET = 1'b0;
    #1 check_reset_state("rst");

    // Narrow read on ch1, latency from trigger to RD pulse.
    REQ_ADDR[1*AW +: AW] = 25'h0200010;
    REQ_DIN[1*DW +: DW]  = 16'h1111;
    push_exp(1, 64'hBEEF_0123_4567_89AB);
    pulse_trig(4'b0010);
    wait_idle();
    check_val("trig_to_pulse", 64'(pulse_cyc - trig_cyc), 3);
    check_val("ch1_data", CH_DATA[1*RW +: RW], 64'h0000_0000_0000_BEEF);

    // Wide read on ch2 must wait for ready_fourth.
    REQ_ADDR[2*AW +: AW] = 25'h1234567;
    push_exp(2, 64'h1122_3344_5566_7788);
    pulse_trig(4'b0100);
    wait_idle();
    check_val("ch2_data", CH_DATA[2*RW +: RW], 64'h1122_3344_5566_7788);
    check_val("ch1_retained", CH_DATA[1*RW +: RW], 64'h0000_0000_0000_BEEF);

    // Simultaneous ch0/ch3 reads.
    REQ_ADDR[0*AW +: AW] = 25'h0000200;
    REQ_ADDR[3*AW +: AW] = 25'h1FFFFFF;
`ifdef ROUND_ROBIN_EN
    push_exp(3, 64'hC3C3_0000_0000_0003);
    push_exp(0, 64'hA0A0_0000_0000_0000);
`else
    push_exp(0, 64'hA0A0_0000_0000_0000);
    push_exp(3, 64'hC3C3_0000_0000_0003);
`endif
    pulse_trig(4'b1001);
    wait_idle();

    // Byte write ch0, then word write ch3.
    REQ_WR = 4'b1001; REQ_BYTE = 4'b0001;
    REQ_ADDR[0*AW +: AW] = 25'h0000100;
    REQ_DIN[0*DW +: DW]  = 16'h00A5;
    REQ_DIN[3*DW +: DW]  = 16'h5A5A;
    push_exp(0, 64'h0);
    n0 = pulse_cnt;
    pulse_trig(4'b0001);
    wait_pulse(n0);
    check_val("bwr_wait_din", sdram_din, 16'h00A5);
    check_val("bwr_wait_wtbt", wtbt, 2'b00);
    check_val("bwr_pulse_once", SDRAM_WR_PULSE, 0);
    wait_idle();
    push_exp(3, 64'h0);
    pulse_trig(4'b1000);
    wait_idle();
    REQ_WR = '0; REQ_BYTE = '0;

    // Retrigger ch1 while it is running gives a second access.
    n0 = pulse_cnt;
    push_exp(1, 64'h1234_0000_0000_0000);
    pulse_trig(4'b0010);
    wait_pulse(n0);
    push_exp(1, 64'h5678_0000_0000_0000);
    pulse_trig(4'b0010);
    wait_idle();
    check_val("retrig_count", 64'(pulse_cnt - n0), 2);
    check_val("retrig_no_overrun", OVERRUN, 0);

    // Download blocks grants; double trigger on ch1 while pending.
    DL_ACTIVE = 1'b1; DL_ADDR = 25'h1ABCDEF; DL_DIN = 16'h7777;
    REQ_ADDR[0*AW +: AW] = 25'h0000300;
    n0 = pulse_cnt;
    push_exp(0, 64'hD0D0_0000_0000_0000);
    push_exp(1, 64'hD1D1_0000_0000_0000);
    pulse_trig(4'b0011);
    pulse_trig(4'b0010);
    repeat (3) tick();
    check_val("dl_overrun", OVERRUN, 4'b0010);
    check_val("dl_busy", CH_BUSY, 4'b0011);
    check_val("dl_addr", sdram_addr, 25'h1ABCDEF);
    check_val("dl_din", sdram_din, 16'h7777);
    check_val("dl_wtbt", wtbt, 2'b11);
    check_val("dl_no_pulse", 64'(pulse_cnt - n0), 0);
    DL_ACTIVE = 1'b0;
    trig_cyc = cyc;
    wait_pulse(n0);
    check_val("dl_fall_to_pulse", 64'(pulse_cyc - trig_cyc), 1);
    wait_idle();
    check_val("overrun_single_access", 64'(pulse_cnt - n0), 2);

    // Disabled channel: request dropped silently.
    REQ_EN = 4'b0111;
    n0 = pulse_cnt;
    pulse_trig(4'b1000);
    repeat (6) tick();
    check_val("drop_busy", CH_BUSY, 0);
    check_val("drop_no_pulse", 64'(pulse_cnt - n0), 0);
    REQ_EN = '1;

    // Reset while ch2 is in WAIT.
    n0 = pulse_cnt;
    push_exp(2, 64'hEEEE_DDDD_CCCC_BBBB);
    pulse_trig(4'b0100);
    wait_pulse(n0);
    tick();
    RESET = 1'b1;
    exp_q.delete();
    tick();
    RESET = 1'b0;
    #1 check_reset_state("midrst");
    n0 = pulse_cnt;
    repeat (15) tick();
    check_val("midrst_no_pulse", 64'(pulse_cnt - n0), 0);
    check_val("midrst_valid", CH_VALID, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
